// File: rtl/block_shift_queue.sv
// block_shift_queue: compacting multi-lane queue; head at element 0, dequeue compacts via block shift.
module block_shift #(
    parameter int W = 8,
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic [N-1:0][W-1:0] data,
    input  logic [S-1:0]        amt,
    output logic [N-1:0][W-1:0] shifted
);
    assign shifted = data >> (W * int'(amt));
endmodule

module block_shift_queue #(
    parameter int DATA  = 8,
    parameter int DEPTH = 8,
    parameter int IN    = 4,
    parameter int OUT   = 4,
    parameter int CNT   = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [$clog2(IN+1)-1:0]      enq_cnt,
    input  logic [IN-1:0][DATA-1:0]      enq_data,
    output logic                         enq_ack,
    input  logic [$clog2(OUT+1)-1:0]     deq_req,
    output logic [$clog2(OUT+1)-1:0]     deq_cnt,
    output logic [OUT-1:0][DATA-1:0]     out_data,
    output logic [OUT-1:0]               out_valid,
    output logic [CNT-1:0]               count,
    output logic [CNT-1:0]               free
);
    localparam int DW = $clog2(OUT + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [DEPTH-1:0][DATA-1:0] mem, shifted, nxt;
    logic [CNT-1:0] base, count_next;
    block_shift #(.W(DATA), .N(DEPTH), .S(DW)) u_shift (
        .data(mem),
        .amt(deq_cnt),
        .shifted(shifted)
    );
    assign deq_cnt    = (CNT'(deq_req) < count) ? deq_req : DW'(count);
    assign free       = CNT'(DEPTH) - count;
    assign enq_ack    = !flush && (int'(enq_cnt) <= int'(free) + int'(deq_cnt));
    assign base       = count - CNT'(deq_cnt);
    assign count_next = base + (enq_ack ? CNT'(enq_cnt) : '0);
    assign out_data   = mem[OUT-1:0];
    always_comb begin
        out_valid = '0;
        for (int i = 0; i < OUT; i++) out_valid[i] = CNT'(i) < count;
    end
    // Accepted lanes land directly behind the entries that survive the dequeue.
    always_comb begin
        nxt = shifted;
        for (int j = 0; j < IN; j++)
            if (enq_ack && ($clog2(IN+1))'(j) < enq_cnt) nxt[IW'(base + CNT'(j))] = enq_data[j];
    end
    always_comb begin
        assert (count <= CNT'(DEPTH) && count >= CNT'(deq_cnt));
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mem   <= '0;
            count <= '0;
        end else begin
            mem   <= nxt;
            count <= count_next;
        end
    end
endmodule

// File: tb/tb_block_shift_queue.sv
// tb_block_shift_queue: queue-model scoreboard checked every cycle, plus directed literal checks.
module tb_block_shift_queue;
    localparam int DATA = 8, DEPTH = 8, IN = 4, OUT = 4, CNT = 4;
    logic clk = 0, reset = 1, flush = 0;
    logic [2:0] enq_cnt = 0, deq_req = 0;
    logic [IN-1:0][DATA-1:0] enq_data = '0;
    logic enq_ack;
    logic [2:0] deq_cnt;
    logic [OUT-1:0][DATA-1:0] out_data;
    logic [OUT-1:0] out_valid;
    logic [CNT-1:0] count, free;
    int checks = 0, errors = 0;
    int mq[$];
    bit armed = 0;

    block_shift_queue #(.DATA(DATA), .DEPTH(DEPTH), .IN(IN), .OUT(OUT)) dut (
        .clk(clk), .reset(reset), .flush(flush), .enq_cnt(enq_cnt), .enq_data(enq_data),
        .enq_ack(enq_ack), .deq_req(deq_req), .deq_cnt(deq_cnt), .out_data(out_data),
        .out_valid(out_valid), .count(count), .free(free)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Model: a plain FIFO of element values, updated by the rules at each edge.
    always @(negedge clk) begin
        int sz, ed;
        bit ea;
        assert (enq_cnt <= IN) else $error("enq_cnt exceeds IN");
        sz = mq.size();
        ed = int'(deq_req) < sz ? int'(deq_req) : sz;
        ea = !flush && int'(enq_cnt) <= DEPTH - sz + ed;
        if (armed) begin
            chk("m_count", 32'(count), sz);
            chk("m_free", 32'(free), DEPTH - sz);
            chk("m_deq_cnt", 32'(deq_cnt), ed);
            chk("m_enq_ack", 32'(enq_ack), 32'(ea));
            for (int i = 0; i < OUT; i++) begin
                chk($sformatf("m_valid%0d", i), 32'(out_valid[i]), 32'(i < sz));
                chk($sformatf("m_data%0d", i), 32'(out_data[i]), i < sz ? mq[i] : 0);
            end
        end
        if (reset || flush) mq.delete();
        else begin
            repeat (ed) void'(mq.pop_front());
            if (ea) for (int j = 0; j < int'(enq_cnt); j++) mq.push_back(int'(enq_data[j]));
        end
        if (reset) armed = 1;
    end

    task automatic cyc(input bit r, input bit f, input int ec, input logic [31:0] d, input int dr);
        @(posedge clk);
        #1;
        reset = r;
        flush = f;
        enq_cnt = 3'(ec);
        enq_data = d;
        deq_req = 3'(dr);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 3); #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_free", 32'(free), 8);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_deq_cnt", 32'(deq_cnt), 0);
        cyc(0, 0, 3, 32'h030201, 0); #1;
        chk("enq3_ack", 32'(enq_ack), 1);
        cyc(0, 0, 0, 0, 0); #1;
        chk("enq3_count", 32'(count), 3);
        chk("enq3_d0", 32'(out_data[0]), 8'h01);
        chk("enq3_d1", 32'(out_data[1]), 8'h02);
        chk("enq3_d2", 32'(out_data[2]), 8'h03);
        chk("enq3_valid", 32'(out_valid), 4'b0111);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 4, 32'h04030201, 0);
        cyc(0, 0, 4, 32'h08070605, 0);
        cyc(0, 0, 1, 32'h99, 0); #1;
        chk("full_ack", 32'(enq_ack), 0);
        chk("full_count", 32'(count), 8);
        cyc(0, 0, 2, 32'h0A09, 2); #1;
        chk("full_swap_ack", 32'(enq_ack), 1);
        chk("full_stay", 32'(count), 8);
        cyc(0, 0, 0, 0, 4); #1;
        chk("swap_count", 32'(count), 8);
        chk("swap_d0", 32'(out_data[0]), 8'h03);
        chk("swap_d1", 32'(out_data[1]), 8'h04);
        chk("swap_deq4", 32'(deq_cnt), 4);
        cyc(0, 0, 0, 0, 0); #1;
        chk("tail_count", 32'(count), 4);
        chk("tail_d3", 32'(out_data[3]), 8'h0A);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 2, 32'h0B0A, 0);
        cyc(0, 0, 4, 32'h13121110, 4); #1;
        chk("clamp_deq", 32'(deq_cnt), 2);
        chk("clamp_ack", 32'(enq_ack), 1);
        cyc(0, 0, 0, 0, 0); #1;
        chk("clamp_count", 32'(count), 4);
        chk("clamp_data", 32'(out_data), 32'h13121110);
        cyc(0, 0, 1, 32'h14, 0);
        cyc(0, 1, 2, 32'h2221, 1); #1;
        chk("flush_ack", 32'(enq_ack), 0);
        chk("flush_deq", 32'(deq_cnt), 1);
        chk("flush_pre", 32'(count), 5);
        cyc(0, 0, 0, 0, 0); #1;
        chk("flush_count", 32'(count), 0);
        chk("flush_data", 32'(out_data), 0);
        chk("flush_valid", 32'(out_valid), 0);
        cyc(0, 0, 4, 32'h04030201, 0);
        cyc(0, 0, 1, 32'h05, 0);
        cyc(1, 0, 2, 32'h2221, 1); #1;
        chk("rst2_deq", 32'(deq_cnt), 1);
        chk("rst2_pre", 32'(count), 5);
        cyc(0, 0, 0, 0, 0); #1;
        chk("rst2_count", 32'(count), 0);
        chk("rst2_data", 32'(out_data), 0);
        for (int k = 0; k < 300; k++)
            cyc(0, $urandom_range(0, 24) == 0, $urandom_range(0, IN), $urandom, $urandom_range(0, OUT));
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/block_shift_queue.md
Name: block_shift_queue

Overview:
- Multi-entry compacting queue.
- Up to IN elements enqueue per cycle and up to OUT elements dequeue per cycle; the head is always at element 0.
- Dequeue compacts storage with a right block shift (non-rotating, zero fill) by the granted dequeue count. Enqueue writes new elements directly behind the surviving entries.
- Sits upstream of multi-issue consumers and supplies the shift amount to its internal block_shift instance.

Parameters:
- DATA, 8, element width in bits
- DEPTH, 8, number of storage elements
- IN, 4, max elements enqueued per cycle
- OUT, 4, max elements dequeued per cycle (OUT <= DEPTH)
- CNT, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all contents this cycle
- enq_cnt  in  $clog2(IN+1)  number of valid enqueue lanes; lanes 0..enq_cnt-1 are valid
- enq_data  in  [IN-1:0][DATA-1:0]  enqueue lanes; lane 0 is oldest
- enq_ack  out  1  enqueue accepted this cycle (combinational)
- deq_req  in  $clog2(OUT+1)  number of elements requested from the head
- deq_cnt  out  $clog2(OUT+1)  granted dequeue count = min(deq_req, count) (combinational)
- out_data  out  [OUT-1:0][DATA-1:0]  head elements 0..OUT-1 (combinational from storage)
- out_valid  out  [OUT-1:0]  out_valid[i] = (i < count)
- count  out  CNT  current occupancy (registered)
- free  out  CNT  DEPTH - count

Behaviour:
- Reset (sync, clk edge with reset=1): count=0, all storage elements=0. Outputs follow: out_data=0, out_valid=0, free=DEPTH, deq_cnt=0. reset overrides flush, enqueue and dequeue.
- Storage invariant: elements at index >= count are always 0.
- Dequeue grant:
  - deq_cnt = min(deq_req, count); any excess request is silently clamped.
  - Head data is valid in the same cycle as the request (zero-latency read); removal takes effect at the next edge.
- Enqueue acceptance:
  - enq_ack = (enq_cnt <= free + deq_cnt) and !flush. Space freed by a same-cycle dequeue counts toward acceptance.
  - enq_cnt = 0 yields enq_ack = 1 with no effect.
  - Rejection is all-or-nothing: no partial enqueue. The producer holds its data and retries.
  - enq_cnt > IN is illegal; behaviour is undefined and flagged by a bench assertion.
- Next state on a clk edge without reset or flush:
  - shifted = storage right-block-shifted by deq_cnt, zero filled (shift only, never rotate).
  - If enq_ack, lanes j < enq_cnt are written to shifted[count - deq_cnt + j].
  - count_next = count - deq_cnt + (enq_ack ? enq_cnt : 0).
- Ordering: elements leave in exactly the order accepted. Lane 0 of an enqueue precedes lane 1, and so on.
- Full (count = DEPTH): an enqueue succeeds only if the same-cycle deq_cnt >= enq_cnt.
- Empty (count = 0): deq_cnt = 0 and out_valid = 0 regardless of deq_req. An enqueue to an empty queue is visible on out_data on the next cycle (no bypass).
- Flush: at the next edge, count=0 and all storage is zeroed. The same-cycle enqueue is dropped (enq_ack=0). deq_cnt is still reported this cycle so the consumer can use the head data presented in the flush cycle.
- count never exceeds DEPTH and never goes negative; an immediate assertion in the RTL checks both.
- No internal state machine beyond the count/storage registers. One-cycle update latency for all state.

Test Plan:
- Reset then idle -> count=0, free=8, out_valid=4'b0000, out_data=0; deq_req=3 gives deq_cnt=0.
- Enqueue enq_cnt=3 data {0x03,0x02,0x01} (lane0=0x01) -> next cycle count=3, out_data[0..2]=0x01,0x02,0x03, out_valid=4'b0111.
- Fill to 8 with two 4-lane enqueues of 0x01..0x08, then enq_cnt=1 with deq_req=0 -> enq_ack=0, count stays 8.
- Same cycle enq_cnt=2 and deq_req=2 -> enq_ack=1, count=8 next cycle, out_data[0..1]=0x03,0x04, and element 7 holds the new lane1 value.
- With count=2 (0x0A,0x0B), deq_req=4 with enq_cnt=4 of 0x10..0x13 -> deq_cnt=2, enq_ack=1, next cycle count=4, out_data=0x10,0x11,0x12,0x13.
- With count=5, flush=1, enq_cnt=2, deq_req=1 -> enq_ack=0, deq_cnt=1; next cycle count=0, storage all zero. Repeat with reset=1 and flush=0 -> identical result.
